// File: rtl/ndp_unit_if.sv
// Stream and result bundle for the ndp_unit systolic MAC array.
// The master drives the operand stream; the slave (the array) returns edge values and accumulators.
interface ndp_unit_if #(
    parameter int WIDTH = 16,
    parameter int ROWS  = 2,
    parameter int COLS  = 2
);
    logic [ROWS*WIDTH-1:0]      in_a;
    logic [COLS*WIDTH-1:0]      in_b;
    logic                       in_done_flag;
    logic [1:0]                 SIMD_Control;
    logic [ROWS*WIDTH-1:0]      out_a;
    logic [COLS*WIDTH-1:0]      out_b;
    logic [ROWS*COLS*WIDTH-1:0] out_c;
    logic                       calc_done_flag;

    modport master (
        output in_a, in_b, in_done_flag, SIMD_Control,
        input  out_a, out_b, out_c, calc_done_flag
    );

    modport slave (
        input  in_a, in_b, in_done_flag, SIMD_Control,
        output out_a, out_b, out_c, calc_done_flag
    );
endinterface

// File: rtl/ndp_unit.sv
// Output-stationary systolic MAC array: skewed a/b streams flow right/down through a PE grid,
// each PE accumulating its element of the outer-product sum; a small FSM flags completion.
module ndp_unit #(
    parameter int WIDTH      = 16,
    parameter int ARR_WIDTH  = 2,
    parameter int ARR_HEIGHT = 2,
    parameter int SYS_WIDTH  = 1,
    parameter int SYS_HEIGHT = 1
) (
    input  logic      clk,
    input  logic      reset,
    ndp_unit_if.slave bus
);
    localparam int ROWS       = ARR_HEIGHT * SYS_HEIGHT;
    localparam int COLS       = ARR_WIDTH * SYS_WIDTH;
    localparam int DONE_EDGES = ROWS + COLS;
    localparam int CNT_W      = $clog2(DONE_EDGES + 1);

    typedef enum logic [1:0] {
        OP_MAC     = 2'b00,
        OP_ADD     = 2'b01,
        OP_MUL     = 2'b10,
        OP_MAC_ALT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DONE
    } state_e;

    op_e op;
    assign op = op_e'(bus.SIMD_Control);

    // Once the stream is finished the array keeps clocking, so feed zeros to flush it.
    logic [ROWS*WIDTH-1:0] a_gated;
    logic [COLS*WIDTH-1:0] b_gated;
    assign a_gated = bus.in_done_flag ? '0 : bus.in_a;
    assign b_gated = bus.in_done_flag ? '0 : bus.in_b;

    logic [WIDTH-1:0] a_edge [ROWS];
    logic [WIDTH-1:0] b_edge [COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_direct
            assign a_edge[r] = a_gated[r*WIDTH +: WIDTH];
        end else begin : g_shift
            logic [WIDTH-1:0] sh_q [r];
            // NOTE: skew stages are reset like any other state so a mid-stream reset flushes them.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < r; i++) sh_q[i] <= '0;
                end else begin
                    sh_q[0] <= a_gated[r*WIDTH +: WIDTH];
                    for (int i = 1; i < r; i++) sh_q[i] <= sh_q[i-1];
                end
            end
            assign a_edge[r] = sh_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_direct
            assign b_edge[c] = b_gated[c*WIDTH +: WIDTH];
        end else begin : g_shift
            logic [WIDTH-1:0] sh_q [c];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < c; i++) sh_q[i] <= '0;
                end else begin
                    sh_q[0] <= b_gated[c*WIDTH +: WIDTH];
                    for (int i = 1; i < c; i++) sh_q[i] <= sh_q[i-1];
                end
            end
            assign b_edge[c] = sh_q[c-1];
        end
    end

    logic [WIDTH-1:0] a_w   [ROWS][COLS];
    logic [WIDTH-1:0] b_w   [ROWS][COLS];
    logic [WIDTH-1:0] acc_w [ROWS][COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe
            logic [WIDTH-1:0] a_in, b_in;
            logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;

            if (c == 0) begin : g_a_left
                assign a_in = a_edge[r];
            end else begin : g_a_chain
                assign a_in = a_w[r][c-1];
            end

            if (r == 0) begin : g_b_top
                assign b_in = b_edge[c];
            end else begin : g_b_chain
                assign b_in = b_w[r-1][c];
            end

            // Operands are WIDTH bits, so products and sums wrap mod 2^WIDTH by construction.
            always_comb begin
                acc_d = acc_q;
                case (op)
                    OP_ADD:  acc_d = acc_q + a_in + b_in;
                    OP_MUL:  acc_d = a_in * b_in;
                    default: acc_d = acc_q + a_in * b_in;
                endcase
            end

            // NOTE: sequential state uses non-blocking assignments so every PE samples pre-edge values.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else begin
                    a_q   <= a_in;
                    b_q   <= b_in;
                    acc_q <= acc_d;
                end
            end

            assign a_w[r][c]   = a_q;
            assign b_w[r][c]   = b_q;
            assign acc_w[r][c] = acc_q;
        end
    end

    // Completion: count DONE_EDGES edges from the first finished-stream edge, then latch done.
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_done_flag) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DONE_EDGES - 1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    done_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        bus.out_a = '0;
        bus.out_b = '0;
        bus.out_c = '0;
        for (int r = 0; r < ROWS; r++) begin
            bus.out_a[r*WIDTH +: WIDTH] = a_w[r][COLS-1];
        end
        for (int c = 0; c < COLS; c++) begin
            bus.out_b[c*WIDTH +: WIDTH] = b_w[ROWS-1][c];
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                bus.out_c[(r*COLS+c)*WIDTH +: WIDTH] = acc_w[r][c];
            end
        end
    end

    assign bus.calc_done_flag = done_q;

endmodule

// File: tb/tb_ndp_unit.sv
// Self-checking bench for ndp_unit (2x2 grid, 16-bit): table of streams with a result scoreboard,
// plus hand sequences for reset, edge pass-through, MUL mode, done stickiness and restart.
module tb_ndp_unit;
    localparam int W = 16;

    logic clk;
    logic reset;

    ndp_unit_if #(.WIDTH(W), .ROWS(2), .COLS(2)) bus ();

    ndp_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        int          nvec;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [63:0] exp_c;   // {acc11, acc10, acc01, acc00}
    } vec_t;

    vec_t        tbl [6];
    logic [63:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] acc_at(input int idx);
        return bus.out_c[idx*W +: W];
    endfunction

    task automatic drive_idle();
        bus.in_a         = '0;
        bus.in_b         = '0;
        bus.in_done_flag = 1'b0;
    endtask

    task automatic apply_reset();
        drive_idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.calc_done_flag && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Present the stream, close it with junk on the data lines, then score the accumulators.
    task automatic run_entry(input int i);
        int          n;
        logic [63:0] exp;
        bus.SIMD_Control = tbl[i].op;
        bus.in_a = tbl[i].a0;
        bus.in_b = tbl[i].b0;
        sb_q.push_back(tbl[i].exp_c);
        tick();
        if (tbl[i].nvec == 2) begin
            bus.in_a = tbl[i].a1;
            bus.in_b = tbl[i].b1;
            tick();
        end
        bus.in_done_flag = 1'b1;
        bus.in_a = {16'hAAAA, 16'h5555};
        bus.in_b = {16'h1234, 16'h4321};
        wait_done(n);
        check($sformatf("t%0d_done_latency", i), 64'(n), 64'd4);
        exp = sb_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t%0d_acc%0d", i, k), 64'(acc_at(k)), 64'(exp[k*W +: W]));
        end
    endtask

    initial begin
        int n;
        int low_cycles;

        tbl[0] = '{2'b00, 2, {16'd2, 16'd1}, {16'd2, 16'd1}, {16'd4, 16'd2}, {16'd3, 16'd4},
                   {16'd16, 16'd18, 16'd8, 16'd9}};
        tbl[1] = '{2'b00, 1, {16'd0, 16'hFFFF}, {16'd0, 16'd2}, 32'd0, 32'd0,
                   {16'd0, 16'd0, 16'd0, 16'hFFFE}};
        tbl[2] = '{2'b01, 1, {16'd2, 16'd1}, {16'd4, 16'd3}, 32'd0, 32'd0,
                   {16'd6, 16'd5, 16'd5, 16'd4}};
        tbl[3] = '{2'b11, 2, {16'd2, 16'd1}, {16'd2, 16'd1}, {16'd4, 16'd2}, {16'd3, 16'd4},
                   {16'd16, 16'd18, 16'd8, 16'd9}};
        tbl[4] = '{2'b00, 1, {16'd7, 16'd300}, {16'd9, 16'd300}, 32'd0, 32'd0,
                   {16'd63, 16'd2100, 16'd2700, 16'd24464}};
        tbl[5] = '{2'b01, 2, {16'd2, 16'd1}, {16'd4, 16'd3}, {16'd10, 16'd20}, {16'd1, 16'd5},
                   {16'd17, 16'd20, 16'd26, 16'd29}};

        bus.SIMD_Control = 2'b00;
        apply_reset();
        check("reset_out_c", 64'(bus.out_c), 64'd0);
        check("reset_done", 64'(bus.calc_done_flag), 64'd0);

        for (int i = 0; i < 6; i++) begin
            apply_reset();
            run_entry(i);
        end

        // Done stays set after the stream flag drops.
        low_cycles = 0;
        bus.in_done_flag = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!bus.calc_done_flag) low_cycles++;
        end
        check("done_sticky_low_cycles", 64'(low_cycles), 64'd0);

        // Async reset between edges clears everything, then a stream starts clean.
        apply_reset();
        bus.SIMD_Control = 2'b00;
        bus.in_a = {16'd7, 16'd5};
        bus.in_b = {16'd3, 16'd2};
        tick();
        bus.in_done_flag = 1'b1;
        bus.in_a = '0;
        bus.in_b = '0;
        wait_done(n);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_out_c", 64'(bus.out_c), 64'd0);
        check("async_rst_out_a", 64'(bus.out_a), 64'd0);
        check("async_rst_out_b", 64'(bus.out_b), 64'd0);
        check("async_rst_done", 64'(bus.calc_done_flag), 64'd0);
        drive_idle();
        #1;
        reset = 1'b1;
        run_entry(1);

        // Edge pass-through latency.
        apply_reset();
        bus.in_a = {16'd7, 16'd5};
        bus.in_b = {16'd11, 16'd9};
        tick();
        drive_idle();
        check("pass_e1_out_a0", 64'(bus.out_a[0 +: W]), 64'd0);
        tick();
        check("pass_e2_out_a0", 64'(bus.out_a[0 +: W]), 64'd5);
        check("pass_e2_out_a1", 64'(bus.out_a[W +: W]), 64'd0);
        check("pass_e2_out_b0", 64'(bus.out_b[0 +: W]), 64'd9);
        tick();
        check("pass_e3_out_a1", 64'(bus.out_a[W +: W]), 64'd7);
        check("pass_e3_out_b1", 64'(bus.out_b[W +: W]), 64'd11);
        check("pass_e3_out_a0", 64'(bus.out_a[0 +: W]), 64'd0);

        // MUL keeps only the latest product.
        apply_reset();
        bus.SIMD_Control = 2'b10;
        bus.in_a = {16'd5, 16'd3};
        bus.in_b = {16'd11, 16'd7};
        tick();
        check("mul_e1_acc00", 64'(acc_at(0)), 64'd21);
        bus.in_a = {16'd1, 16'd6};
        bus.in_b = {16'd1, 16'd4};
        tick();
        check("mul_e2_acc00", 64'(acc_at(0)), 64'd24);
        check("mul_e2_acc01", 64'(acc_at(1)), 64'd33);
        drive_idle();

        // A second rise of the flag before done does not restart the count.
        bus.SIMD_Control = 2'b00;
        apply_reset();
        bus.in_done_flag = 1'b1;
        tick();
        bus.in_done_flag = 1'b0;
        tick();
        tick();
        check("restart_e3_done", 64'(bus.calc_done_flag), 64'd0);
        bus.in_done_flag = 1'b1;
        tick();
        check("restart_e4_done", 64'(bus.calc_done_flag), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
